// File: rtl/encoder_pkg.sv
// Shared definitions for the quadrature encoder front-end.
// Contents:
//   PH_00..PH_10     phase number of each filtered {A,B} pin pair
//   DIR_CW/DIR_CCW   encoding of the dir output
//   acc_t            signed edge accumulator (holds +/-EDGES_PER_DET, up to +/-7)
//   delta_e          result of comparing two consecutive phases
//   ab_to_phase()    {A,B} -> phase number (Gray order 00,01,11,10)
//   gray_delta()     classifies a phase change as CW, CCW, none or illegal
package encoder_pkg;

  localparam logic [1:0] PH_00 = 2'd0;
  localparam logic [1:0] PH_01 = 2'd1;
  localparam logic [1:0] PH_11 = 2'd2;
  localparam logic [1:0] PH_10 = 2'd3;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  typedef logic signed [3:0] acc_t;

  typedef enum logic [1:0] {
    DeltaNone,
    DeltaCw,
    DeltaCcw,
    DeltaErr
  } delta_e;

  function automatic logic [1:0] ab_to_phase(input logic [1:0] ab);
    logic [1:0] ph;
    unique case (ab)
      2'b00:   ph = PH_00;
      2'b01:   ph = PH_01;
      2'b11:   ph = PH_11;
      default: ph = PH_10;
    endcase
    return ph;
  endfunction

  function automatic delta_e gray_delta(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] prev_ph;
    logic [1:0] cur_ph;
    delta_e     res;
    prev_ph = ab_to_phase(prev_ab);
    cur_ph  = ab_to_phase(cur_ab);
    if (prev_ph == cur_ph) begin
      res = DeltaNone;
    end else if (cur_ph == prev_ph + 2'd1) begin
      res = DeltaCw;
    end else if (cur_ph == prev_ph - 2'd1) begin
      res = DeltaCcw;
    end else begin
      // Both pins moved at once: direction is unknowable.
      res = DeltaErr;
    end
    return res;
  endfunction

endpackage

// File: rtl/pin_debounce.sv
// Synchroniser plus debounce filter for one raw encoder pin.
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   pin_raw   asynchronous pin input
//   pin_filt  filtered level; flips only after DEBOUNCE_CYC consecutive synced samples
//             disagree with it
module pin_debounce #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_raw,
  output logic pin_filt
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   synced;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign pin_filt = filt_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_raw};
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (synced == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      // This sample is the DEBOUNCE_CYC-th disagreeing one.
      filt_d = synced;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/quad_encoder_counter.sv
// Rotary encoder channel: debounced quadrature decode, detent accumulator and a bounded
// up/down setting value.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   enc_a, enc_b          raw quadrature pins
//   enable                1: detents move value; 0: detents decoded but value frozen
//   clear, load_en        synchronous clear / load (clear wins, both beat detents)
//   load_value            value to load, clamped to max_value
//   max_value             inclusive upper bound of value
//   value                 current setting
//   step                  1-cycle pulse when a detent changes value
//   dir                   direction of last applied detent (1 = CW)
//   enc_err               1-cycle pulse on an illegal (both-pin) transition
// Build option: define ENC_WRAP_EN to wrap at the bounds instead of saturating.
module quad_encoder_counter #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DEBOUNCE_CYC  = 16,
  parameter int          EDGES_PER_DET = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enable,
  input  logic             clear,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] max_value,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir,
  output logic             enc_err
);

  import encoder_pkg::*;

  localparam acc_t AccTop = acc_t'(EDGES_PER_DET);
  localparam acc_t AccBot = acc_t'(-EDGES_PER_DET);

  logic             a_filt, b_filt;
  logic [1:0]       cur_ab;
  logic [1:0]       prev_ab_q, prev_ab_d;
  acc_t             acc_q, acc_d, acc_inc, acc_dec;
  logic             err_q, err_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             det_cw, det_ccw;
  delta_e           delta;
  logic [WIDTH:0]   max_ext, inc_ext, dec_ext;

  pin_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb_a (
    .clk     (clk),
    .rst     (rst),
    .pin_raw (enc_a),
    .pin_filt(a_filt)
  );

  pin_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb_b (
    .clk     (clk),
    .rst     (rst),
    .pin_raw (enc_b),
    .pin_filt(b_filt)
  );

  assign cur_ab = {a_filt, b_filt};

  // Decoder and accumulator.
  always_comb begin
    prev_ab_d = cur_ab;
    acc_d     = acc_q;
    acc_inc   = acc_q + acc_t'(1);
    acc_dec   = acc_q - acc_t'(1);
    err_d     = 1'b0;
    det_cw    = 1'b0;
    det_ccw   = 1'b0;
    delta     = gray_delta(prev_ab_q, cur_ab);
    unique case (delta)
      DeltaCw: begin
        if (acc_inc == AccTop) begin
          acc_d  = '0;
          det_cw = 1'b1;
        end else begin
          acc_d = acc_inc;
        end
      end
      DeltaCcw: begin
        if (acc_dec == AccBot) begin
          acc_d   = '0;
          det_ccw = 1'b1;
        end else begin
          acc_d = acc_dec;
        end
      end
      DeltaErr:  err_d = 1'b1;
      DeltaNone: ;
    endcase
  end

  // Value register; one extra bit exposes overflow/underflow.
  always_comb begin
    max_ext = {1'b0, max_value};
    inc_ext = {1'b0, value_q} + 1'b1;
    dec_ext = {1'b0, value_q} - 1'b1;
    value_d = value_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    if (clear) begin
      value_d = '0;
    end else if (load_en) begin
      value_d = (load_value > max_value) ? max_value : load_value;
    end else if (value_q > max_value) begin
      value_d = max_value;
    end else if (enable && (det_cw || det_ccw)) begin
      dir_d = det_cw ? DIR_CW : DIR_CCW;
      if (det_cw) begin
        if (inc_ext > max_ext) begin
`ifdef ENC_WRAP_EN
          value_d = '0;
          step_d  = (value_q != '0);
`endif
        end else begin
          value_d = inc_ext[WIDTH-1:0];
          step_d  = 1'b1;
        end
      end else begin
        if (dec_ext[WIDTH]) begin
`ifdef ENC_WRAP_EN
          value_d = max_value;
          step_d  = (max_value != '0);
`endif
        end else begin
          value_d = dec_ext[WIDTH-1:0];
          step_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ab_q <= 2'b00;
      acc_q     <= '0;
      err_q     <= 1'b0;
      value_q   <= '0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      prev_ab_q <= prev_ab_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      value_q   <= value_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
    end
  end

  assign value   = value_q;
  assign step    = step_q;
  assign dir     = dir_q;
  assign enc_err = err_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Scoreboard bench for quad_encoder_counter: expected step/enc_err pulses are queued as
// stimulus is applied and popped by a monitor whenever the DUT pulses.
module tb_quad_encoder_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_a, enc_b, enable, clear, load_en;
  logic [7:0] load_value, max_value, value;
  logic       step, dir, enc_err;

  always #5 clk = ~clk;

  quad_encoder_counter dut (
    .clk       (clk),
    .rst       (rst),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .enable    (enable),
    .clear     (clear),
    .load_en   (load_en),
    .load_value(load_value),
    .max_value (max_value),
    .value     (value),
    .step      (step),
    .dir       (dir),
    .enc_err   (enc_err)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] val;
    logic       dir;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  int  n_tests = 0;
  int  n_fail  = 0;

`ifdef ENC_WRAP_EN
  localparam bit Wrap = 1'b1;
`else
  localparam bit Wrap = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pins(input logic a, input logic b, input int n);
    enc_a = a;
    enc_b = b;
    hold(n);
  endtask

  task automatic push_step(input logic [7:0] v, input logic d);
    exp_q.push_back('{is_err: 1'b0, val: v, dir: d});
  endtask

  task automatic push_err();
    exp_q.push_back('{is_err: 1'b1, val: 8'd0, dir: 1'b0});
  endtask

  task automatic do_load(input logic [7:0] v);
    load_value = v;
    load_en    = 1'b1;
    hold(1);
    load_en    = 1'b0;
    hold(1);
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && (step || enc_err)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: step=%0b enc_err=%0b value=%0d, required no pulse",
                 step, enc_err, value);
      end else begin
        ev = exp_q.pop_front();
        if (enc_err !== ev.is_err || step !== !ev.is_err ||
            (!ev.is_err && (value !== ev.val || dir !== ev.dir))) begin
          n_fail++;
          $display("FAIL pulse: got step=%0b err=%0b value=%0d dir=%0b, required err=%0b value=%0d dir=%0b",
                   step, enc_err, value, dir, ev.is_err, ev.val, ev.dir);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    enc_a = 1'b1; enc_b = 1'b1;
    enable = 1'b1; clear = 1'b0; load_en = 1'b0;
    load_value = 8'd0; max_value = 8'd10;

    // 1: reset with pins at 11; release gives one illegal 00->11 transition.
    hold(3);
    check("reset_value", value, 0);
    check("reset_step", step, 0);
    check("reset_err", enc_err, 0);
    check("reset_dir", dir, 0);
    push_err();
    rst = 1'b0;
    hold(40);
    check("post_reset_value", value, 0);
    push_err();
    pins(0, 0, 40);

    // 2: one CW detent then one CCW detent.
    pins(0, 1, 40); pins(1, 1, 40); pins(1, 0, 40);
    push_step(8'd1, 1'b1);
    pins(0, 0, 40);
    check("cw_value", value, 1);
    check("cw_dir", dir, 1);
    pins(1, 0, 40); pins(1, 1, 40); pins(0, 1, 40);
    push_step(8'd0, 1'b0);
    pins(0, 0, 40);
    check("ccw_value", value, 0);
    check("ccw_dir", dir, 0);

    // 3: CW at max, CCW at 0.
    do_load(8'd10);
    check("load10", value, 10);
    pins(0, 1, 40); pins(1, 1, 40); pins(1, 0, 40);
    if (Wrap) push_step(8'd0, 1'b1);
    pins(0, 0, 40);
    check("cw_at_max_value", value, Wrap ? 0 : 10);
    check("cw_at_max_dir", dir, 1);
    clear = 1'b1; hold(1); clear = 1'b0; hold(1);
    check("clear_value", value, 0);
    pins(1, 0, 40); pins(1, 1, 40); pins(0, 1, 40);
    if (Wrap) push_step(8'd10, 1'b0);
    pins(0, 0, 40);
    check("ccw_at_zero_value", value, Wrap ? 10 : 0);
    check("ccw_at_zero_dir", dir, 0);

    // 4: 15-cycle glitch rejected, 16-cycle pulse accepted (final edge of a CW detent).
    do_load(8'd5);
    pins(0, 1, 40); pins(1, 1, 40); pins(1, 0, 40);
    pins(0, 0, 15);
    pins(1, 0, 40);
    check("glitch15_value", value, 5);
    push_step(8'd6, 1'b1);
    pins(0, 0, 16);
    pins(1, 0, 40);
    check("pulse16_value", value, 6);
    check("pulse16_dir", dir, 1);
    // Filtered A returned high (one CCW edge); finish that CCW detent.
    pins(1, 1, 40); pins(0, 1, 40);
    push_step(8'd5, 1'b0);
    pins(0, 0, 40);
    check("recover_value", value, 5);

    // 5: both pins flip together.
    push_err();
    pins(1, 1, 40);
    check("err_value_a", value, 5);
    push_err();
    pins(0, 0, 40);
    check("err_value_b", value, 5);

    // 6: clear overlapping a detent, load clamp, lowering max.
    pins(0, 1, 40); pins(1, 1, 40); pins(1, 0, 40);
    enc_a = 1'b0;
    hold(16);
    clear = 1'b1;
    hold(5);
    clear = 1'b0;
    hold(30);
    check("clear_vs_detent", value, 0);
    do_load(8'd20);
    check("load_clamp", value, 10);
    max_value = 8'd3;
    hold(1);
    check("max_lowered", value, 3);
    hold(5);
    check("max_lowered_hold", value, 3);

    check("events_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
